// File: rtl/serial_word_collector.sv
// Serial-to-parallel word collector with an overlapping pattern detector
// and a saturating, clearable match counter.
module serial_word_collector #(
  parameter int unsigned                 WIDTH   = 8,
  parameter int unsigned                 PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0]          PATTERN = 4'b1011,
  parameter int unsigned                 CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             din_en,
  input  logic             clr_cnt,
  output logic [WIDTH-1:0] word,
  output logic             word_valid,
  output logic             match,
  output logic [CNT_W-1:0] match_count,
  output logic             cnt_sat
);

  localparam int unsigned BC_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam int unsigned FC_W = (PAT_LEN > 2) ? $clog2(PAT_LEN) : 1;

  typedef enum logic {FILL, ARMED} state_t;

  state_t             r_state;
  logic [WIDTH-2:0]   r_sr;
  logic [BC_W-1:0]    r_bitcnt;
  logic [PAT_LEN-2:0] r_hist;
  logic [FC_W-1:0]    r_fill;
  logic [WIDTH-1:0]   r_word;
  logic               r_word_valid;
  logic               r_match;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_cnt_sat;

  logic [WIDTH-1:0]   w_shift;
  logic [PAT_LEN-1:0] w_window;
  logic               w_ready;
  logic               w_hit;
  logic [CNT_W-1:0]   w_cnt_nxt;

  assign w_shift  = {r_sr, din};
  assign w_window = {r_hist, din};
  // The PAT_LEN-th bit already completes a full window, so it may match.
  assign w_ready  = (r_state == ARMED) || (r_fill == FC_W'(PAT_LEN - 1));
  assign w_hit    = din_en && w_ready && (w_window == PATTERN);

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (clr_cnt)
      w_cnt_nxt = '0;
    else if (w_hit && (r_cnt != '1))
      w_cnt_nxt = r_cnt + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= FILL;
      r_sr         <= '0;
      r_bitcnt     <= '0;
      r_hist       <= '0;
      r_fill       <= '0;
      r_word       <= '0;
      r_word_valid <= 1'b0;
      r_match      <= 1'b0;
      r_cnt        <= '0;
      r_cnt_sat    <= 1'b0;
    end else begin
      r_cnt        <= w_cnt_nxt;
      r_cnt_sat    <= &w_cnt_nxt;
      r_word_valid <= 1'b0;
      r_match      <= 1'b0;
      if (din_en) begin
        r_sr    <= w_shift[WIDTH-2:0];
        r_hist  <= w_window[PAT_LEN-2:0];
        r_match <= w_hit;
        if (r_bitcnt == BC_W'(WIDTH - 1)) begin
          r_bitcnt     <= '0;
          r_word       <= w_shift;
          r_word_valid <= 1'b1;
        end else begin
          r_bitcnt <= r_bitcnt + BC_W'(1);
        end
        case (r_state)
          FILL: begin
            if (r_fill == FC_W'(PAT_LEN - 1))
              r_state <= ARMED;
            else
              r_fill <= r_fill + FC_W'(1);
          end
          ARMED: r_state <= ARMED;
          default: r_state <= FILL;
        endcase
      end
    end
  end

  assign word        = r_word;
  assign word_valid  = r_word_valid;
  assign match       = r_match;
  assign match_count = r_cnt;
  assign cnt_sat     = r_cnt_sat;

endmodule

// File: tb/tb_serial_word_collector.sv
// Self-checking bench: directed scenarios plus random streams, compared every
// cycle against a bit-history model (default counter width and a 2-bit counter).
module tb_serial_word_collector;

  localparam int unsigned W = 8;
  localparam int unsigned P = 4;
  localparam logic [3:0]  PAT = 4'b1011;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       din = 1'b0;
  logic       din_en = 1'b0;
  logic       clr_cnt = 1'b0;

  logic [7:0] word, word_s;
  logic       word_valid, word_valid_s;
  logic       match, match_s;
  logic [7:0] match_count;
  logic [1:0] match_count_s;
  logic       cnt_sat, cnt_sat_s;

  serial_word_collector u_dut (
    .clk(clk), .rst(rst), .din(din), .din_en(din_en), .clr_cnt(clr_cnt),
    .word(word), .word_valid(word_valid), .match(match),
    .match_count(match_count), .cnt_sat(cnt_sat)
  );

  serial_word_collector #(.CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .din(din), .din_en(din_en), .clr_cnt(clr_cnt),
    .word(word_s), .word_valid(word_valid_s), .match(match_s),
    .match_count(match_count_s), .cnt_sat(cnt_sat_s)
  );

  always #5 clk = ~clk;

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;

  bit          q[$];
  int unsigned n_bits;
  logic [7:0]  m_word;
  logic        m_wv, m_match;
  int unsigned m_cnt8, m_cnt2;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] last_bits(input int unsigned k);
    logic [31:0] v = '0;
    for (int unsigned i = q.size() - k; i < q.size(); i++)
      v = {v[30:0], q[i]};
    return v;
  endfunction

  task automatic model_edge(input logic b, input logic en, input logic clr, input logic r);
    if (r) begin
      q.delete();
      n_bits = 0;
      m_word = '0; m_wv = 1'b0; m_match = 1'b0;
      m_cnt8 = 0;  m_cnt2 = 0;
      return;
    end
    m_wv = 1'b0;
    m_match = 1'b0;
    if (en) begin
      q.push_back(b);
      if (q.size() > 32) void'(q.pop_front());
      n_bits++;
      if (n_bits % W == 0) begin
        m_word = last_bits(W);
        m_wv = 1'b1;
      end
      m_match = (n_bits >= P) && (last_bits(P) == 32'(PAT));
    end
    if (clr) begin
      m_cnt8 = 0; m_cnt2 = 0;
    end else if (m_match) begin
      if (m_cnt8 < 255) m_cnt8++;
      if (m_cnt2 < 3)   m_cnt2++;
    end
  endtask

  task automatic step(input logic b, input logic en, input logic clr, input logic r);
    @(negedge clk);
    din = b; din_en = en; clr_cnt = clr; rst = r;
    @(posedge clk);
    #1;
    model_edge(b, en, clr, r);
    check("word",      32'(word),          32'(m_word));
    check("wvalid",    32'(word_valid),    32'(m_wv));
    check("match",     32'(match),         32'(m_match));
    check("count",     32'(match_count),   m_cnt8);
    check("sat",       32'(cnt_sat),       32'(m_cnt8 == 255));
    check("s_match",   32'(match_s),       32'(m_match));
    check("s_count",   32'(match_count_s), m_cnt2);
    check("s_sat",     32'(cnt_sat_s),     32'(m_cnt2 == 3));
  endtask

  task automatic feed(input logic [31:0] bits, input int unsigned len);
    logic [31:0] v;
    v = bits;
    for (int unsigned i = 0; i < len; i++)
      step(v[len-1-i], 1'b1, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1);
  endtask

  initial begin
    int unsigned wv_seen;
    int unsigned m_seen;

    // Reset with active data inputs
    do_reset();
    check("rst_word",  32'(word), 32'h0);
    check("rst_count", 32'(match_count), 32'h0);

    // 0xA5: one word, no match
    wv_seen = 0; m_seen = 0;
    for (int unsigned i = 0; i < 8; i++) begin
      feed(32'(8'hA5 >> (7 - i)) & 32'h1, 1);
      wv_seen += 32'(word_valid);
      m_seen  += 32'(match);
    end
    check("a5_word",   32'(word), 32'hA5);
    check("a5_wvcnt",  wv_seen, 1);
    check("a5_nomatch", m_seen, 0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("a5_wv_drop", 32'(word_valid), 32'h0);

    // First word 0x54, single match after bit 12
    do_reset();
    feed(32'h54, 8);
    check("w54_word", 32'(word), 32'h54);
    feed(32'b1011, 4);
    check("p12_match", 32'(match), 32'h1);
    check("p12_count", 32'(match_count), 32'h1);
    feed(32'b0, 1);
    check("p13_count", 32'(match_count), 32'h1);

    // Overlapping hits
    do_reset();
    feed(32'b1011, 4);
    check("ov4_match", 32'(match), 32'h1);
    feed(32'b011, 3);
    check("ov7_match", 32'(match), 32'h1);
    check("ov7_count", 32'(match_count), 32'h2);

    // Enable gaps inside a word
    do_reset();
    feed(32'b101, 3);
    for (int unsigned i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
    feed(32'b00101, 5);
    check("gap_word", 32'(word), 32'hA5);
    check("gap_wv",   32'(word_valid), 32'h1);

    // Saturation of the 2-bit counter, then clear on a matching edge
    do_reset();
    feed(32'b1011011011011, 13);
    check("sat_count", 32'(match_count_s), 32'h3);
    check("sat_flag",  32'(cnt_sat_s), 32'h1);
    feed(32'b01, 2);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    check("clr_match", 32'(match_s), 32'h1);
    check("clr_count", 32'(match_count_s), 32'h0);
    check("clr_sat",   32'(cnt_sat_s), 32'h0);

    // Reset mid-word discards history
    feed(32'b101, 3);
    do_reset();
    feed(32'b1, 1);
    check("midrst_nomatch", 32'(match), 32'h0);

    // Random traffic
    for (int unsigned i = 0; i < 3000; i++) begin
      step(1'($urandom), ($urandom_range(0, 9) < 8), ($urandom_range(0, 99) < 3),
           ($urandom_range(0, 199) == 0));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/serial_word_collector.md
Name: serial_word_collector

Overview:
- Downstream consumer of the single-bit registered D flip-flop output (Q).
- Deserializes the bit stream MSB-first into WIDTH-bit words.
- Runs an overlapping pattern detector on the same stream and keeps a saturating count of pattern hits.
- Feeds parallel words and match events to later control logic.

Parameters:
- WIDTH, 8: bits per deserialized word (2..32).
- PAT_LEN, 4: pattern length in bits (2..WIDTH).
- PATTERN, 4'b1011: pattern to detect. The MSB is the earliest bit received.
- CNT_W, 8: width of the match counter.

Ports:
- clk, input, 1: rising-edge clock.
- rst, input, 1: synchronous, active-high reset.
- din, input, 1: serial data bit (driven by the flip-flop Q).
- din_en, input, 1: qualifies din. A bit is consumed only on edges where din_en=1.
- clr_cnt, input, 1: synchronous clear of match_count and cnt_sat.
- word, output, WIDTH: last completed word. Held until the next word completes.
- word_valid, output, 1: one-cycle pulse; word is new.
- match, output, 1: one-cycle pulse; the last PAT_LEN consumed bits equal PATTERN.
- match_count, output, CNT_W: number of matches, saturating.
- cnt_sat, output, 1: high while match_count is all-ones.

Behaviour:
- Reset (rst=1 at a clk edge): shift register, history, bit counter, word, match_count = 0. word_valid, match, cnt_sat = 0. FSM = FILL. rst overrides all other inputs. Reset mid-word discards the partial word and pattern history.
- Shift: on an edge with din_en=1, sr <= {sr[WIDTH-2:0], din} and bitcnt increments. When bitcnt==WIDTH-1, bitcnt wraps to 0.
- Word output: on the edge consuming the WIDTH-th bit, word <= {sr[WIDTH-2:0], din} and word_valid=1 for that single cycle (registered, visible after that edge). Words are back-to-back with no gap cycle.
- din_en=0: no state change. word_valid and match drop to 0.
- Pattern FSM:
  - FILL: counts consumed bits up to PAT_LEN-1. No match is possible.
  - On the edge consuming the PAT_LEN-th bit since reset, go to ARMED.
  - ARMED: on each consuming edge, compare {hist[PAT_LEN-2:0], din} with PATTERN. If equal, match=1 for one cycle (registered).
  - Overlapping matches are counted; history is not flushed after a hit.
  - FILL is re-entered only on reset.
  - The pattern detector is independent of word boundaries.
- Counter: increments on each match event. At all-ones it holds and cnt_sat=1.
- clr_cnt=1: match_count <= 0 and cnt_sat <= 0, with priority over a same-edge increment. The match pulse itself is still emitted.
- Latency: one clk edge from consumed bit to word_valid/match.

Test Plan:
- Reset with rst=1, din=1, din_en=1 for 2 cycles -> word=0, word_valid=0, match=0, match_count=0 throughout.
- Stream 0xA5 MSB-first (1,0,1,0,0,1,0,1), din_en=1 every cycle -> word_valid pulses once after the 8th bit, word=8'hA5, match never asserts, match_count=0.
- Bits 0,1,0,1,0,1,0,0,1,0,1,1,0 (one per clock) -> single match pulse after the 12th bit, match_count=1. First word = 8'h54 after bit 8.
- Overlap: bits 1,0,1,1,0,1,1 -> match after bits 4 and 7, match_count=2.
- din_en gaps: 0xA5 with din_en low for 3 cycles between bits 3 and 4 -> word=8'hA5 still, word_valid only after the 8th enabled bit.
- Saturation/clear: CNT_W=2, 4 matches -> match_count=3, cnt_sat=1. Then clr_cnt on the same edge as a 5th match -> match=1, match_count=0, cnt_sat=0.
